// File: rtl/skeleton_bus_interconnect_pkg.sv
// Purpose: shared constants, address map and FSM state type for the skeleton bus interconnect.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package skeleton_bus_interconnect_pkg;

    localparam int NUM_MASTERS    = 4;
    localparam int NUM_SLAVES     = 2;
    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int TIMEOUT_CYCLES = 255;

    // Address map
    localparam int unsigned USB_OFFSET = 35840;
    localparam int unsigned USB_SIZE   = 1024;
    localparam int unsigned RAM_OFFSET = 8192;
    localparam int unsigned RAM_SIZE   = 256;

    localparam int SLV_USB = 0;
    localparam int SLV_RAM = 1;

    // Indexed by slave number (SLV_USB, SLV_RAM)
    localparam int unsigned SLAVE_BASE [NUM_SLAVES] = '{USB_OFFSET, RAM_OFFSET};
    localparam int unsigned SLAVE_SIZE [NUM_SLAVES] = '{USB_SIZE, RAM_SIZE};

    localparam int MIDX_W = $clog2(NUM_MASTERS);
    localparam int SIDX_W = $clog2(NUM_SLAVES);
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DECODE, ACCESS, RESP} state_t;

    // base <= addr < base+size, evaluated in 32 bits so base+size cannot wrap
    function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                      input int unsigned base,
                                      input int unsigned size);
        int unsigned a;
        a = 32'(addr);
        return (a >= base) && (a < base + size);
    endfunction

endpackage

// File: rtl/skeleton_rr_arbiter.sv
// Purpose: round-robin pick of the first requester at or after ptr, wrapping modulo NUM_MASTERS.
// Latency: combinational; the pointer register lives in the parent.
// Backpressure: none; gnt_vld is low when no request is present.
// Ports: req (request vector), ptr (search start), gnt_idx (winner), gnt_vld (any request).
module skeleton_rr_arbiter
    import skeleton_bus_interconnect_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MIDX_W-1:0]      ptr,
    output logic [MIDX_W-1:0]      gnt_idx,
    output logic                   gnt_vld
);

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!gnt_vld && req[(int'(ptr) + i) % NUM_MASTERS]) begin
                gnt_vld = 1'b1;
                gnt_idx = MIDX_W'((int'(ptr) + i) % NUM_MASTERS);
            end
        end
    end

endmodule

// File: rtl/skeleton_bus_interconnect.sv
// Purpose: shared bus from NUM_MASTERS req/ack masters to NUM_SLAVES mapped slaves, round-robin arbitrated.
// Latency: s_sel 2 cycles after the request is seen in IDLE; m_ack 1 cycle after s_ack (cycle 2 if unmapped).
// Backpressure: masters hold m_req until m_ack; a silent slave is abandoned after TIMEOUT_CYCLES with m_err.
// Ports: clk/rst_n; m_req/m_wr/m_addr/m_wdata in, m_ack/m_err/m_rdata out (master side);
//        s_sel/s_wr/s_addr/s_wdata out, s_ack/s_rdata in (slave side, s_addr is slave-local offset).
module skeleton_bus_interconnect
    import skeleton_bus_interconnect_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_wr,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_SLAVES-1:0]         s_sel,
    output logic                          s_wr,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [NUM_SLAVES-1:0]         s_ack,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata
);

    state_t              state;
    logic [MIDX_W-1:0]   rr_ptr;
    logic [MIDX_W-1:0]   gnt_idx;
    logic [SIDX_W-1:0]   slv_idx;
    logic [CNT_W-1:0]    to_cnt;

    logic [MIDX_W-1:0]   arb_idx;
    logic                arb_vld;

    logic [ADDR_W-1:0]   gnt_addr;
    logic                dec_hit;
    logic [SIDX_W-1:0]   dec_idx;
    logic [ADDR_W-1:0]   dec_off;

    logic                sel_ack;
    logic [DATA_W-1:0]   sel_rdata;

    skeleton_rr_arbiter u_arb (
        .req     (m_req),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign gnt_addr  = m_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_ack   = s_ack[slv_idx];
    assign sel_rdata = s_rdata[slv_idx*DATA_W +: DATA_W];

    // First matching range wins; ranges are disjoint in the current map.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        dec_off = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (!dec_hit && addr_hit(gnt_addr, SLAVE_BASE[s], SLAVE_SIZE[s])) begin
                dec_hit = 1'b1;
                dec_idx = SIDX_W'(s);
                dec_off = ADDR_W'(32'(gnt_addr) - SLAVE_BASE[s]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            slv_idx <= '0;
            to_cnt  <= '0;
            m_ack   <= '0;
            m_err   <= '0;
            m_rdata <= '0;
            s_sel   <= '0;
            s_wr    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
        end else begin
            // m_ack/m_err are single-cycle pulses
            m_ack <= '0;
            m_err <= '0;
            case (state)
                IDLE: begin
                    if (arb_vld) begin
                        gnt_idx <= arb_idx;
                        rr_ptr  <= (int'(arb_idx) == NUM_MASTERS - 1) ? '0 : arb_idx + 1'b1;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_hit) begin
                        s_sel   <= NUM_SLAVES'(1) << dec_idx;
                        s_addr  <= dec_off;
                        s_wr    <= m_wr[gnt_idx];
                        s_wdata <= m_wdata[gnt_idx*DATA_W +: DATA_W];
                        slv_idx <= dec_idx;
                        to_cnt  <= '0;
                        state   <= ACCESS;
                    end else begin
                        m_ack[gnt_idx] <= 1'b1;
                        m_err[gnt_idx] <= 1'b1;
                        m_rdata        <= '0;
                        state          <= RESP;
                    end
                end
                ACCESS: begin
                    to_cnt <= to_cnt + 1'b1;
                    // Ack is tested first so it wins over a coincident timeout
                    if (sel_ack) begin
                        s_sel          <= '0;
                        s_wr           <= 1'b0;
                        m_ack[gnt_idx] <= 1'b1;
                        m_rdata        <= sel_rdata;
                        state          <= RESP;
                    end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // This is the TIMEOUT_CYCLES-th cycle with s_sel high
                        s_sel          <= '0;
                        s_wr           <= 1'b0;
                        m_ack[gnt_idx] <= 1'b1;
                        m_err[gnt_idx] <= 1'b1;
                        m_rdata        <= '0;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    to_cnt <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skeleton_bus_interconnect.sv
// Purpose: self-checking bench for skeleton_bus_interconnect against a transaction-level model.
// Latency: model expects s_sel at request+2, m_ack at s_ack+1, timeout after 255 select cycles.
// Backpressure: bench masters hold m_req until m_ack, bench slaves ack after a chosen delay or never.
module tb_skeleton_bus_interconnect;

    localparam int TMO = 255;

    logic        clk;
    logic        rst_n;
    logic [3:0]  m_req;
    logic [3:0]  m_wr;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [3:0]  m_ack;
    logic [3:0]  m_err;
    logic [15:0] m_rdata;
    logic [1:0]  s_sel;
    logic        s_wr;
    logic [15:0] s_addr;
    logic [15:0] s_wdata;
    logic [1:0]  s_ack;
    logic [31:0] s_rdata;

    int          total;
    int          bad;
    int          mptr;
    logic [3:0]  last_ack;

    int unsigned map_base [2] = '{35840, 8192};
    int unsigned map_size [2] = '{1024, 256};
    logic [15:0] edge_addr [8] = '{16'd8191, 16'd8192, 16'd8447, 16'd8448,
                                   16'd35839, 16'd35840, 16'd36863, 16'd36864};

    skeleton_bus_interconnect dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_req   (m_req),
        .m_wr    (m_wr),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .s_sel   (s_sel),
        .s_wr    (s_wr),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_ack   (s_ack),
        .s_rdata (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got running, need finished)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-robin reference: first pending master at or after the pointer
    task automatic model_pick(output int g);
        g = -1;
        for (int i = 0; i < 4; i++) begin
            if (g < 0 && m_req[(mptr + i) % 4]) g = (mptr + i) % 4;
        end
        if (g >= 0) mptr = (g + 1) % 4;
    endtask

    task automatic decode_ref(input logic [15:0] a, output int slv, output int off);
        slv = -1;
        off = 0;
        for (int s = 0; s < 2; s++) begin
            if (slv < 0 && int'(a) >= int'(map_base[s]) && int'(a) < int'(map_base[s] + map_size[s])) begin
                slv = s;
                off = int'(a) - int'(map_base[s]);
            end
        end
    endtask

    task automatic set_m(input int g, input logic [15:0] a, input logic wr, input logic [15:0] wd);
        m_addr[g*16 +: 16]  = a;
        m_wr[g]             = wr;
        m_wdata[g*16 +: 16] = wd;
        m_req[g]            = 1'b1;
    endtask

    function automatic logic [15:0] rand_addr();
        int          cat;
        logic [15:0] a;
        cat = int'($urandom_range(0, 3));
        case (cat)
            0:       a = 16'(8192 + $urandom_range(0, 255));
            1:       a = 16'(35840 + $urandom_range(0, 1023));
            2:       a = edge_addr[$urandom_range(0, 7)];
            default: a = 16'($urandom);
        endcase
        return a;
    endfunction

    // Called at the negedge of the cycle in which the DUT (in IDLE) sees the requests.
    // ack_k: s_ack delay in cycles after s_sel rises (-1 = never); noise_k: cycle of a stray ack
    // from the other slave; rearm keeps the master requesting after its ack.
    task automatic txn(input int ack_k, input int noise_k, input logic [15:0] rd, input bit rearm);
        int          g;
        int          slv;
        int          off;
        int          exp_cyc;
        int          cyc;
        bit          sel_ok;
        bit          got;
        bit          ok_path;
        logic [15:0] a;
        model_pick(g);
        if (g < 0) begin
            check("no_requester", 32'(m_req), 32'hFFFF_FFFF);
            return;
        end
        a = m_addr[g*16 +: 16];
        decode_ref(a, slv, off);
        @(negedge clk);
        check("sel_in_decode", 32'(s_sel), 32'd0);
        if (slv < 0) begin
            @(negedge clk);
            last_ack = m_ack;
            check("miss_ack", 32'(m_ack), 32'(1) << g);
            check("miss_err", 32'(m_err), 32'(1) << g);
            check("miss_rdata", 32'(m_rdata), 32'd0);
            check("miss_sel", 32'(s_sel), 32'd0);
        end else begin
            ok_path = (ack_k >= 0) && (ack_k < TMO);
            exp_cyc = ok_path ? 3 + ack_k : 2 + TMO;
            sel_ok  = 1'b1;
            got     = 1'b0;
            for (cyc = 2; cyc < 2 + TMO + 5; cyc++) begin
                @(negedge clk);
                if (m_ack != 4'd0) begin
                    got = 1'b1;
                    break;
                end
                if (cyc == 2) begin
                    check("s_addr", 32'(s_addr), 32'(off));
                    check("s_wr", 32'(s_wr), 32'(m_wr[g]));
                    check("s_wdata", 32'(s_wdata), 32'(m_wdata[g*16 +: 16]));
                end
                if (s_sel !== (2'b01 << slv)) sel_ok = 1'b0;
                s_ack   = 2'b00;
                s_rdata = $urandom;
                if (cyc - 2 == ack_k) begin
                    s_ack[slv]            = 1'b1;
                    s_rdata[slv*16 +: 16] = rd;
                end else if (cyc - 2 == noise_k) begin
                    s_ack[1-slv] = 1'b1;
                end
            end
            s_ack    = 2'b00;
            last_ack = m_ack;
            check("ack_seen", 32'(got), 32'd1);
            check("ack_cycle", 32'(cyc), 32'(exp_cyc));
            check("sel_stable", 32'(sel_ok), 32'd1);
            check("ack_vec", 32'(m_ack), 32'(1) << g);
            check("err_vec", 32'(m_err), ok_path ? 32'd0 : (32'(1) << g));
            check("rdata", 32'(m_rdata), ok_path ? 32'(rd) : 32'd0);
            check("sel_in_resp", 32'(s_sel), 32'd0);
        end
        if (!rearm) m_req[g] = 1'b0;
        @(negedge clk);
        check("ack_single_pulse", 32'(m_ack), 32'd0);
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int ack_k;
    int noise_k;
    int pick;
    logic [3:0] mask;

    initial begin
        total   = 0;
        bad     = 0;
        mptr    = 0;
        rst_n   = 1'b0;
        m_req   = '0;
        m_wr    = '0;
        m_addr  = '0;
        m_wdata = '0;
        s_ack   = '0;
        s_rdata = '0;
        last_ack = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_m_ack", 32'(m_ack), 32'd0);
        check("rst_m_err", 32'(m_err), 32'd0);
        check("rst_m_rdata", 32'(m_rdata), 32'd0);
        check("rst_s_sel", 32'(s_sel), 32'd0);
        check("rst_s_wr", 32'(s_wr), 32'd0);
        check("rst_s_addr", 32'(s_addr), 32'd0);
        check("rst_s_wdata", 32'(s_wdata), 32'd0);

        // All four masters continuously requesting from reset
        rst_n = 1'b1;
        set_m(0, 16'd8200, 1'b0, 16'h0000);
        set_m(1, 16'd35900, 1'b1, 16'h1111);
        set_m(2, 16'd8300, 1'b1, 16'h2222);
        set_m(3, 16'd36000, 1'b0, 16'h3333);
        for (int i = 0; i < 5; i++) begin
            txn(1, -1, 16'($urandom), 1'b1);
            check("rr_order", 32'(last_ack), 32'(1) << order[i]);
        end
        while (m_req != 4'd0) txn(0, -1, 16'($urandom), 1'b0);

        // Master 2 reads 8200, slave acks 3 cycles later with BEEF
        mptr = mptr;
        set_m(2, 16'd8200, 1'b0, 16'h0000);
        txn(3, -1, 16'hBEEF, 1'b0);
        check("beef_rdata", 32'(m_rdata), 32'h0000_BEEF);

        // Master 0 writes top of USB range, then one past it
        set_m(0, 16'd36863, 1'b1, 16'h1234);
        txn(1, -1, 16'($urandom), 1'b0);
        set_m(0, 16'd36864, 1'b1, 16'h1234);
        txn(1, -1, 16'($urandom), 1'b0);

        // Silent slave, then a normal transaction
        set_m(1, 16'd8192, 1'b0, 16'h0000);
        txn(-1, -1, 16'($urandom), 1'b0);
        set_m(1, 16'd8447, 1'b0, 16'h0000);
        txn(0, -1, 16'h5A5A, 1'b0);

        // Ack on the timeout cycle wins; stray ack from the other slave is ignored
        set_m(3, 16'd35840, 1'b0, 16'h0000);
        txn(TMO - 1, 2, 16'hC0DE, 1'b0);
        set_m(2, 16'd8250, 1'b1, 16'h7777);
        txn(5, 1, 16'h4321, 1'b0);

        // Reset in the middle of an access
        set_m(2, 16'd8200, 1'b0, 16'h0000);
        repeat (4) @(negedge clk);
        check("pre_rst_sel", 32'(s_sel), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_s_sel", 32'(s_sel), 32'd0);
        check("arst_m_ack", 32'(m_ack), 32'd0);
        check("arst_s_addr", 32'(s_addr), 32'd0);
        m_req = '0;
        mptr  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        set_m(3, 16'd8200, 1'b0, 16'h0000);
        txn(2, -1, 16'h3C3C, 1'b0);
        check("post_rst_grant", 32'(last_ack), 32'h8);

        // Randomized rounds
        for (int r = 0; r < 30; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int m = 0; m < 4; m++) begin
                if (mask[m]) set_m(m, rand_addr(), 1'($urandom), 16'($urandom));
            end
            while (m_req != 4'd0) begin
                pick = int'($urandom_range(0, 19));
                if (pick == 0)      ack_k = -1;
                else if (pick == 1) ack_k = TMO - 1;
                else                ack_k = int'($urandom_range(0, 6));
                noise_k = (pick > 10) ? int'($urandom_range(0, 6)) : -1;
                txn(ack_k, noise_k, 16'($urandom), 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
